spike_rate_encoder: RTL and testbench
=====================================

# spike_rate_encoder

- Drives the `inputs[0:8]` spike bus and `learn` pin of `neuron`: the transmit side of the neuron's spike input interface.
- Holds one 8-bit intensity per input channel, loaded over a valid/ready stream.
- On `start`, emits a stochastic rate-coded spike train for `WINDOW` cycles. Channel i spikes each cycle with probability ≈ intensity[i]/256, using a shared LFSR.
- Pulses `done` at the end of the presentation window.

## Interface

Parameters:
- `CHANNELS`, 9, number of spike outputs; matches the neuron input bus.
- `WINDOW`, 16, presentation length in cycles (1..255).
- `SEED`, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_data`  in  8  intensity for the next channel in load order.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  encoder accepts a load beat.
- `start`  in  1  begin a presentation; sampled only in ARMED.
- `learn_in`  in  1  learning enable from the controller.
- `spikes`  out  [0:CHANNELS-1]  registered spike bus; bit 0 is channel 0.
- `learn`  out  1  `learn_in` gated to the presentation window.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at end of presentation.

## Operation

- State machine:
  - LOAD (reset state): `load_ready`=1. Each accepted beat (`load_valid & load_ready`) writes intensity[idx] and increments idx. The beat with idx==CHANNELS-1 sets idx←0 and moves to ARMED.
  - ARMED: `load_ready`=1.
    - Accepted load beat: writes intensity[0], idx←1, → LOAD.
    - Else `start`=1: → RUN.
    - Simultaneous load beat and `start`: load wins, `start` is ignored.
  - RUN: `load_ready`=0. Stays for exactly WINDOW cycles, then → DONE.
  - DONE: `done`=1 for one cycle, → ARMED. Intensities are retained, so a further `start` re-presents the same pattern.
- `start` is ignored in LOAD, RUN and DONE.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts left; the feedback bit is b7^b5^b4^b3 and enters at b0.
  - Advances exactly once per spike-update edge, i.e. WINDOW times per presentation.
  - Reloaded to SEED only by `reset`, never reseeded between presentations.
- Per-channel comparison value: r_i = LFSR rotated left by (i mod 8).
- Spike rule: spike_i = (intensity[i] > r_i), unsigned 8-bit compare.
  - Intensity 0 never spikes.
  - Intensity 255 spikes except when r_i==8'hFF.
- `learn` = `learn_in` & (state==RUN), combinational.
- Reset values:
  - Registers: state=LOAD, idx=0, all intensities=0, LFSR=SEED, step counter=0.
  - Outputs: `spikes`=0, `done`=0, `busy`=0.
  - `load_ready`=1 (LOAD); `learn`=0, since state is not RUN.

## Timing

- Edge E0 samples `start` in ARMED. At E0:
  - state←RUN
  - `spikes`←compare(current LFSR)
  - LFSR advances
  - step←1
- Each later edge in RUN with step<WINDOW: `spikes`←compare, LFSR advances, step←step+1.
- Edge with step==WINDOW: `spikes`←0, state←DONE.
- `spikes` therefore carries valid data for exactly the WINDOW cycles following E0, and is 0 at all other times.
- `busy` and `learn` are high for the same WINDOW cycles.
- `done` is high in cycle WINDOW+1 after E0. A `start` held high returns the block to RUN one cycle after DONE.
- Minimum start-to-start period: WINDOW+2 cycles.
- Load throughput: one beat per cycle. Gaps in `load_valid` are allowed.
- `reset` mid-RUN: on the next cycle `spikes`=0, state=LOAD, and intensities are cleared. A reload is required.

## Test plan

- Reset: assert `reset` for 2 cycles, then hold `load_valid`=0 and `start`=0.
  - Required: `spikes`=0, `load_ready`=1, `busy`=0, `done`=0.
  - Pulsing `start` alone produces no spikes, because the block is still in LOAD.
- Load with gaps: drive 9 beats (0,32,64,…,255 clipped) with `load_valid` toggling every other cycle.
  - Exactly 9 beats are accepted and the block enters ARMED.
  - `start` in ARMED raises `busy` for exactly 16 cycles and `done` once.
- Extremes: intensity[0]=0 and intensity[1]=255, WINDOW=16.
  - Channel 0 spike count = 0.
  - Channel 1 spikes every window cycle except where r_1==8'hFF, checked against a bench LFSR model from SEED.
- Bit-exact rates: random intensities, 4 back-to-back presentations.
  - `spikes` matches the bench LFSR model cycle-for-cycle.
  - LFSR state continues across presentations with no reseed.
- Priority and gating: in ARMED, assert `load_valid` and `start` together.
  - Required: no RUN; load index=1.
  - With `learn_in`=1 held constantly, `learn` is high only during the RUN cycles.
- Reset mid-run: assert `reset` at step 5 of RUN.
  - Next cycle: `spikes`=0 and `busy`=0.
  - After reset: `load_ready`=1, and the LFSR output restarts from SEED on the next presentation.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike source for the neuron input bus: holds one intensity per channel,
// then emits LFSR-driven Bernoulli spike trains for a fixed presentation window.
module spike_rate_encoder #(
    parameter int         CHANNELS = 9,
    parameter int         WINDOW   = 16,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          load_data,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                start,
    input  logic                learn_in,
    output logic [0:CHANNELS-1] spikes,
    output logic                learn,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {LOAD, ARMED, RUN, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          intensity [CHANNELS];
    logic [7:0]          lfsr;
    logic [7:0]          lfsr_next;
    logic [7:0]          step;
    logic [0:CHANNELS-1] spike_next;
    logic                beat;

    // Each channel sees a different rotation of the shared LFSR to decorrelate neighbours.
    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] d;
        d = {v, v};
        return d[4'd15 - {1'b0, n} -: 8];
    endfunction

    assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign load_ready = (state == LOAD) || (state == ARMED);
    assign beat       = load_valid && load_ready;
    assign learn      = learn_in && (state == RUN);

    always_comb begin
        spike_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            spike_next[i] = intensity[i] > rotl8(lfsr, 3'(i % 8));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD;
            idx    <= '0;
            lfsr   <= SEED;
            step   <= '0;
            spikes <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                intensity[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (beat) begin
                        intensity[idx] <= load_data;
                        if (idx == IDX_W'(CHANNELS - 1)) begin
                            idx   <= '0;
                            state <= ARMED;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    // A load beat restarts the pattern and takes priority over start.
                    if (beat) begin
                        intensity[0] <= load_data;
                        idx          <= IDX_W'(1);
                        state        <= LOAD;
                    end else if (start) begin
                        state  <= RUN;
                        spikes <= spike_next;
                        lfsr   <= lfsr_next;
                        step   <= 8'd1;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (step == 8'(WINDOW)) begin
                        spikes <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        step   <= '0;
                        state  <= DONE;
                    end else begin
                        spikes <= spike_next;
                        lfsr   <= lfsr_next;
                        step   <= step + 8'd1;
                    end
                end
                DONE: begin
                    state <= ARMED;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: stimulus pushes LFSR-model spike vectors,
// a negedge monitor pops and compares them while busy is high.
module tb_spike_rate_encoder;

    localparam int         CH   = 9;
    localparam int         W    = 16;
    localparam logic [7:0] SEED = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    load_data;
    logic          load_valid;
    logic          load_ready;
    logic          start;
    logic          learn_in;
    logic [0:CH-1] spikes;
    logic          learn;
    logic          busy;
    logic          done;

    spike_rate_encoder #(.CHANNELS(CH), .WINDOW(W), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .start(start), .learn_in(learn_in),
        .spikes(spikes), .learn(learn), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [0:CH-1] exp_q [$];
    logic [0:CH-1] exp_v;
    logic [7:0]    lfsr_m;
    logic [7:0]    inten_m [CH];
    logic [7:0]    vals [CH];
    int            busy_cycles, done_cnt, beats;
    int            ch_count [CH];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [0:CH-1] model_spikes();
        logic [0:CH-1] v;
        logic [15:0]   d;
        logic [7:0]    r;
        d = {lfsr_m, lfsr_m};
        for (int i = 0; i < CH; i++) begin
            r    = 8'(d >> (8 - (i % 8)));
            v[i] = inten_m[i] > r;
        end
        return v;
    endfunction

    task automatic model_push(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_spikes());
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s);
        load_valid = v;
        load_data  = d;
        start      = s;
        tick();
    endtask

    task automatic load_pattern(input logic [7:0] p [CH], input bit gaps);
        for (int i = 0; i < CH; i++) begin
            applyStimulus(1'b1, p[i], 1'b0);
            inten_m[i] = p[i];
            if (gaps) applyStimulus(1'b0, 8'd0, 1'b0);
        end
        load_valid = 1'b0;
    endtask

    task automatic clear_counts();
        busy_cycles = 0;
        done_cnt    = 0;
        for (int i = 0; i < CH; i++) ch_count[i] = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic present(input string tag);
        bit seen;
        clear_counts();
        model_push(W);
        applyStimulus(1'b0, 8'd0, 1'b1);
        start = 1'b0;
        wait_done(W + 10, seen);
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        tick();
        checkOutput({tag, "_busy_cycles"}, busy_cycles, W);
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    // Monitor: compares spikes against the scoreboard whenever busy, and idle-zero otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (load_valid && load_ready) beats++;
            if (busy) begin
                busy_cycles++;
                for (int i = 0; i < CH; i++) if (spikes[i]) ch_count[i]++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_busy: got spikes %0h with empty queue", spikes);
                end else begin
                    exp_v = exp_q.pop_front();
                    checkOutput("spikes", 32'(spikes), 32'(exp_v));
                end
                checkOutput("learn_run", 32'(learn), 32'(learn_in));
            end else begin
                checkOutput("spikes_idle", 32'(spikes), 32'd0);
                checkOutput("learn_idle", 32'(learn), 32'd0);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   seen;
        int   exp_ch1;
        logic [7:0] l;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'd0;
        start      = 1'b0;
        learn_in   = 1'b0;
        lfsr_m     = SEED;
        beats      = 0;
        for (int i = 0; i < CH; i++) inten_m[i] = 8'd0;
        clear_counts();
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_spikes", 32'(spikes), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        tick();

        $display("[TB] start ignored in LOAD");
        clear_counts();
        applyStimulus(1'b0, 8'd0, 1'b1);
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("load_start_busy", 32'(busy), 32'd0);
        checkOutput("load_start_cycles", busy_cycles, 0);
        tick();

        $display("[TB] load with gaps");
        beats = 0;
        for (int i = 0; i < CH; i++) vals[i] = (i == 8) ? 8'd255 : 8'(i * 32);
        load_pattern(vals, 1'b1);
        @(negedge clk);
        checkOutput("gap_beats", beats, 9);
        checkOutput("gap_ready_armed", 32'(load_ready), 32'd1);
        tick();
        present("gaps");

        $display("[TB] extremes");
        vals = '{8'd0, 8'd255, 8'd10, 8'd50, 8'd90, 8'd130, 8'd170, 8'd210, 8'd250};
        load_pattern(vals, 1'b0);
        exp_ch1 = 0;
        l = lfsr_m;
        for (int k = 0; k < W; k++) begin
            if ({l[6:0], l[7]} != 8'hFF) exp_ch1++;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        present("extremes");
        checkOutput("ch0_count", ch_count[0], 0);
        checkOutput("ch1_count", ch_count[1], exp_ch1);

        $display("[TB] back-to-back presentations");
        for (int i = 0; i < CH; i++) vals[i] = 8'($urandom_range(0, 255));
        load_pattern(vals, 1'b0);
        clear_counts();
        model_push(4 * W);
        start = 1'b1;
        for (int p = 0; p < 4; p++) begin
            wait_done(W + 10, seen);
            checkOutput("b2b_done_seen", 32'(seen), 32'd1);
        end
        tick();
        start = 1'b0;
        checkOutput("b2b_busy_cycles", busy_cycles, 4 * W);
        checkOutput("b2b_done_count", done_cnt, 4);
        checkOutput("b2b_queue_left", exp_q.size(), 0);
        tick();
        @(negedge clk);
        checkOutput("b2b_stopped", 32'(busy), 32'd0);
        tick();

        $display("[TB] load/start priority and learn gating");
        learn_in = 1'b1;
        clear_counts();
        applyStimulus(1'b1, 8'd77, 1'b1);
        inten_m[0] = 8'd77;
        load_valid = 1'b0;
        start      = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("prio_no_run", 32'(busy), 32'd0);
        checkOutput("prio_busy_cycles", busy_cycles, 0);
        tick();
        vals = '{8'd0, 8'd255, 8'd200, 8'd150, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6};
        for (int i = 1; i < CH; i++) begin
            applyStimulus(1'b1, vals[i], 1'b0);
            inten_m[i] = vals[i];
        end
        load_valid = 1'b0;
        present("prio");

        $display("[TB] reset mid-run");
        model_push(W);
        applyStimulus(1'b0, 8'd0, 1'b1);
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        lfsr_m = SEED;
        for (int i = 0; i < CH; i++) inten_m[i] = 8'd0;
        @(negedge clk);
        checkOutput("mid_rst_spikes", 32'(spikes), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(load_ready), 32'd1);
        tick();
        clear_counts();
        applyStimulus(1'b0, 8'd0, 1'b1);
        start = 1'b0;
        repeat (3) tick();
        checkOutput("mid_rst_needs_reload", busy_cycles, 0);
        vals = '{8'd200, 8'd128, 8'd64, 8'd255, 8'd1, 8'd180, 8'd90, 8'd30, 8'd240};
        load_pattern(vals, 1'b0);
        present("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
